lsu_ram_adapter: RTL and testbench
==================================

// Module: lsu_ram_adapter
// PURPOSE
//  Bridges the core load/store unit to the single-port byte-write RAM (32-bit, 4 byte lanes, sync read, 1-cycle latency).
//  Accepts byte/half/word requests over a valid/ready handshake and generates per-lane write enables and replicated write data.
//  Extracts and sign/zero-extends read data, flags misaligned or illegal accesses, and returns one response per request.
//  Holds at most one transaction in flight.
// PARAMETERS
//  ADDR_WIDTH  14  byte-address width; passed unchanged to the RAM, which indexes words by addr>>2
// PORTS
//  clk           in   1           clock, all state on rising edge
//  rst           in   1           async active-high reset
//  req_valid     in   1           request present
//  req_ready     out  1           adapter accepts the request this cycle
//  req_we        in   1           1=store, 0=load
//  req_size      in   2           00=byte 01=half 10=word 11=illegal
//  req_unsigned  in   1           loads only: 1=zero-extend, 0=sign-extend
//  req_addr      in   ADDR_WIDTH  byte address
//  req_wdata     in   32          store data, LSB-aligned
//  rsp_valid     out  1           response present
//  rsp_ready     in   1           consumer takes the response
//  rsp_rdata     out  32          extended load data; 0 for stores and errors
//  rsp_err       out  1           misaligned or illegal access
//  ram_we        out  4           per-lane write enable to RAM
//  ram_addr      out  ADDR_WIDTH  RAM byte address, = req_addr (combinational)
//  ram_di        out  32          RAM write data
//  ram_dout      in   32          RAM read data, valid 1 cycle after address
// BEHAVIOUR
//  Reset values: state IDLE, rsp_valid=0, rsp_rdata=0, rsp_err=0; req_ready=0 and ram_we=0 while rst is high.
//  Accept = req_valid && req_ready. Signals sampled only in the accept cycle.
//  FSM states:
//   IDLE:    req_ready=1.
//            Accept of an error request -> RESP.
//            Accept of a good store -> RESP.
//            Accept of a good load -> RD_WAIT.
//   RD_WAIT: req_ready=0. Register the extracted ram_dout into rsp_rdata -> RESP.
//   RESP:    rsp_valid=1; rsp_rdata and rsp_err held stable.
//            req_ready=rsp_ready, so a new request may be accepted in the same cycle the response is taken.
//            rsp_ready with no new accept -> IDLE.
//            rsp_ready with a new accept -> next state per the IDLE rules.
//            rsp_ready=0 -> stay in RESP.
//  Error conditions (no RAM write; RESP with rsp_err=1, rsp_rdata=0):
//   half with addr[0]=1; word with addr[1:0]!=0; size=11.
//  Latency: store/error accepted at edge N -> rsp_valid in cycle N+1. Load -> rsp_valid in cycle N+2.
//  Stores: ram_we is combinational and nonzero only in a good store accept cycle. Lane L = addr[1:0].
//   byte: we = 0001<<L, di = {4{wdata[7:0]}}
//   half: we = 0011<<L, di = {2{wdata[15:0]}}
//   word: we = 1111,    di = wdata
//   ram_di = 0 when ram_we=0.
//  Loads: the size, lane and unsigned flag are registered at accept and used in RD_WAIT.
//   byte: ram_dout[8L+7:8L], extended from bit 7
//   half: ram_dout[8L+15:8L], extended from bit 15
//   word: no extension
//  Reset mid-operation: outputs go to reset values immediately (async) and no response is produced for a dropped transaction.
//   A store whose ram_we fired before reset remains written.
//  ram_addr tracks req_addr at all times. A RAM read in a non-accept cycle is harmless; its result is ignored.
// TESTING
//  RAM word@0x100 preloaded 0xDEADBEEF.
//  1 LB 0x103 signed -> rsp_rdata 0xFFFFFFDE, err 0, rsp_valid 2 cycles after accept. LBU 0x101 -> 0x000000BE.
//  2 LH 0x102 signed -> 0xFFFFDEAD. LHU 0x100 -> 0x0000BEEF. LW 0x100 -> 0xDEADBEEF.
//  3 SB 0x101 wdata 0x12345678 -> ram_we 0010, ram_di 0x78787878, rsp next cycle. Then LW 0x100 -> 0xDEAD78EF.
//  4 LW 0x102, SH 0x101, size=11 -> rsp_err 1, rsp_rdata 0, ram_we 0 throughout, RAM unchanged.
//  5 rsp_ready=0 for 5 cycles after an LW -> rsp_valid/rdata stable, req_ready 0.
//    Then rsp_ready=1 with SW 0x104 0xA5A5A5A5 pending -> accepted same cycle, ram_we 1111, its rsp the next cycle.
//  6 rst pulsed in RD_WAIT -> rsp_valid 0 at once. After release: IDLE, req_ready 1, no stray response.

Source files
------------

// File: rtl/lsu_ram_adapter_if.sv
// lsu_ram_adapter_if: LSU request/response handshake plus single-port byte-write RAM port
// Ports (slave = adapter side):
//   req_*  : LSU request (valid/ready, we, size, unsigned, addr, wdata)
//   rsp_*  : response back to the LSU (valid/ready, rdata, err)
//   ram_*  : RAM write enables, byte address, write data, read data
interface lsu_ram_adapter_if #(parameter int ADDR_WIDTH = 14);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [1:0]            req_size;
    logic                  req_unsigned;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [31:0]           req_wdata;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [31:0]           rsp_rdata;
    logic                  rsp_err;
    logic [3:0]            ram_we;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [31:0]           ram_di;
    logic [31:0]           ram_dout;
    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready, ram_dout,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, ram_we, ram_addr, ram_di
    );
    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready, ram_dout,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, ram_we, ram_addr, ram_di
    );
endinterface

// File: rtl/lsu_ram_adapter.sv
// lsu_ram_adapter: bridges the LSU valid/ready interface to a 32-bit byte-write sync-read RAM
// Ports:
//   clk  : clock, all state on rising edge
//   rst  : async active-high reset
//   bus  : lsu_ram_adapter_if.slave carrying request, response and RAM signals
module lsu_ram_adapter #(
    parameter int ADDR_WIDTH = 14
) (
    input logic clk,
    input logic rst,
    lsu_ram_adapter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RD_WAIT, RESP} state_t;
    state_t state, state_nxt;
    logic [ADDR_WIDTH-1:0] addr;
    logic [1:0] lane, sz_q, lane_q;
    logic uns_q, accept, bad, good_store;
    logic [31:0] shifted, ext;
    assign addr = bus.req_addr;
    assign lane = addr[1:0];
    assign bad = (bus.req_size == 2'b11) || (bus.req_size == 2'b01 && addr[0]) ||
                 (bus.req_size == 2'b10 && addr[1:0] != 2'b00);
    // RESP forwards rsp_ready so a new request can ride on the cycle its predecessor is consumed
    assign bus.req_ready = !rst && (state == IDLE || (state == RESP && bus.rsp_ready));
    assign accept = bus.req_valid && bus.req_ready;
    assign good_store = accept && bus.req_we && !bad;
    // Load lane data is picked from the word using the lane/size captured at accept
    assign shifted = bus.ram_dout >> {lane_q, 3'b000};
    assign ext = sz_q == 2'b00 ? {{24{!uns_q && shifted[7]}}, shifted[7:0]} :
                 sz_q == 2'b01 ? {{16{!uns_q && shifted[15]}}, shifted[15:0]} : shifted;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end
    always_comb begin
        state_nxt = state;
        if (state == RD_WAIT)
            state_nxt = RESP;
        else if (accept)
            state_nxt = (bad || bus.req_we) ? RESP : RD_WAIT;
        else if (state == RESP && bus.rsp_ready)
            state_nxt = IDLE;
    end
    always_comb begin
        bus.rsp_valid = state == RESP;
        bus.ram_addr  = addr;
        bus.ram_we    = !good_store          ? 4'b0000 :
                        bus.req_size == 2'b00 ? 4'b0001 << lane :
                        bus.req_size == 2'b01 ? 4'b0011 << lane : 4'b1111;
        bus.ram_di    = !good_store          ? 32'h0 :
                        bus.req_size == 2'b00 ? {4{bus.req_wdata[7:0]}} :
                        bus.req_size == 2'b01 ? {2{bus.req_wdata[15:0]}} : bus.req_wdata;
    end
    // Accepts only happen outside RD_WAIT, so the two update arms never collide
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sz_q          <= 2'b00;
            lane_q        <= 2'b00;
            uns_q         <= 1'b0;
            bus.rsp_rdata <= 32'h0;
            bus.rsp_err   <= 1'b0;
        end else if (state == RD_WAIT) begin
            bus.rsp_rdata <= ext;
            bus.rsp_err   <= 1'b0;
        end else if (accept) begin
            sz_q          <= bus.req_size;
            lane_q        <= lane;
            uns_q         <= bus.req_unsigned;
            bus.rsp_rdata <= 32'h0;
            bus.rsp_err   <= bad;
        end
    end
endmodule

// File: tb/tb_lsu_ram_adapter.sv
// tb_lsu_ram_adapter: scoreboard bench for lsu_ram_adapter with a behavioural byte-write RAM
module tb_lsu_ram_adapter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic preload = 1'b1;
    int checks = 0;
    int errors = 0;
    typedef struct {
        logic [31:0] rd;
        logic        err;
    } exp_t;
    exp_t sbq[$];
    exp_t mon_e;
    logic [31:0] mem [4096];
    logic [3:0]  we_seen;
    logic [31:0] di_seen;

    lsu_ram_adapter_if #(.ADDR_WIDTH(14)) bus ();
    lsu_ram_adapter #(.ADDR_WIDTH(14)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (preload)
            mem[12'h040] <= 32'hDEADBEEF;
        else
            for (int i = 0; i < 4; i++)
                if (bus.ram_we[i])
                    mem[bus.ram_addr[13:2]][8*i +: 8] <= bus.ram_di[8*i +: 8];
        bus.ram_dout <= mem[bus.ram_addr[13:2]];
    end

    always @(negedge clk) begin
        if (!rst && bus.rsp_valid && bus.rsp_ready) begin
            checks++;
            if (sbq.size() == 0) begin
                errors++;
                $display("FAIL stray_rsp: got rdata=%h err=%b, expected no response", bus.rsp_rdata, bus.rsp_err);
            end else begin
                mon_e = sbq.pop_front();
                if (bus.rsp_rdata !== mon_e.rd || bus.rsp_err !== mon_e.err) begin
                    errors++;
                    $display("FAIL rsp: got rdata=%h err=%b, expected rdata=%h err=%b",
                             bus.rsp_rdata, bus.rsp_err, mon_e.rd, mon_e.err);
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 right after the accepting edge
    task automatic issue(input logic we, input logic [1:0] size, input logic uns, input logic [13:0] addr,
                         input logic [31:0] wdata, input logic [31:0] erd, input logic eerr, input bit push);
        bit ok = 0;
        if (push) sbq.push_back('{erd, eerr});
        bus.req_valid = 1'b1;
        bus.req_we = we;
        bus.req_size = size;
        bus.req_unsigned = uns;
        bus.req_addr = addr;
        bus.req_wdata = wdata;
        for (int n = 0; n < 50 && !ok; n++) begin
            @(negedge clk);
            ok = bus.req_ready;
        end
        we_seen = bus.ram_we;
        di_seen = bus.ram_di;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL accept_timeout: addr=%h req_ready=%b, expected 1", addr, bus.req_ready);
        end
        checks++;
        if (bus.ram_addr !== addr) begin
            errors++;
            $display("FAIL ram_addr: got %h, expected %h", bus.ram_addr, addr);
        end
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (sbq.size() != 0 && n < 20);
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d responses outstanding, expected 0", sbq.size());
        end
    endtask

    task automatic test_reset();
        bus.req_valid = 1'b1;
        bus.req_we = 1'b1;
        bus.req_size = 2'b10;
        bus.req_unsigned = 1'b0;
        bus.req_addr = 14'h200;
        bus.req_wdata = 32'h11111111;
        bus.rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks += 5;
        if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL rst_req_ready: got %b, expected 0", bus.req_ready); end
        if (bus.ram_we !== 4'h0) begin errors++; $display("FAIL rst_ram_we: got %b, expected 0000", bus.ram_we); end
        if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid: got %b, expected 0", bus.rsp_valid); end
        if (bus.rsp_rdata !== 32'h0) begin errors++; $display("FAIL rst_rsp_rdata: got %h, expected 0", bus.rsp_rdata); end
        if (bus.rsp_err !== 1'b0) begin errors++; $display("FAIL rst_rsp_err: got %b, expected 0", bus.rsp_err); end
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        rst = 1'b0;
        preload = 1'b0;
        @(negedge clk);
        checks += 2;
        if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL idle_req_ready: got %b, expected 1", bus.req_ready); end
        if (bus.ram_di !== 32'h0) begin errors++; $display("FAIL idle_ram_di: got %h, expected 0", bus.ram_di); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_loads();
        issue(1'b0, 2'b00, 1'b0, 14'h103, 32'h0, 32'hFFFFFFDE, 1'b0, 1);
        @(negedge clk);
        checks++;
        if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL load_lat_n1: rsp_valid=%b, expected 0", bus.rsp_valid); end
        @(negedge clk);
        checks++;
        if (bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL load_lat_n2: rsp_valid=%b, expected 1", bus.rsp_valid); end
        @(posedge clk);
        #1;
        issue(1'b0, 2'b00, 1'b1, 14'h101, 32'h0, 32'h000000BE, 1'b0, 1);
        issue(1'b0, 2'b01, 1'b0, 14'h102, 32'h0, 32'hFFFFDEAD, 1'b0, 1);
        issue(1'b0, 2'b01, 1'b1, 14'h100, 32'h0, 32'h0000BEEF, 1'b0, 1);
        issue(1'b0, 2'b10, 1'b0, 14'h100, 32'h0, 32'hDEADBEEF, 1'b0, 1);
        drain();
    endtask

    task automatic test_store_byte();
        issue(1'b1, 2'b00, 1'b0, 14'h101, 32'h12345678, 32'h0, 1'b0, 1);
        checks += 2;
        if (we_seen !== 4'b0010) begin errors++; $display("FAIL sb_we: got %b, expected 0010", we_seen); end
        if (di_seen !== 32'h78787878) begin errors++; $display("FAIL sb_di: got %h, expected 78787878", di_seen); end
        @(negedge clk);
        checks += 3;
        if (bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL store_lat: rsp_valid=%b, expected 1", bus.rsp_valid); end
        if (bus.ram_we !== 4'h0) begin errors++; $display("FAIL post_store_we: got %b, expected 0000", bus.ram_we); end
        if (bus.ram_di !== 32'h0) begin errors++; $display("FAIL post_store_di: got %h, expected 0", bus.ram_di); end
        @(posedge clk);
        #1;
        issue(1'b0, 2'b10, 1'b0, 14'h100, 32'h0, 32'hDEAD78EF, 1'b0, 1);
        drain();
    endtask

    task automatic test_store_half();
        issue(1'b1, 2'b01, 1'b0, 14'h10A, 32'h0000CAFE, 32'h0, 1'b0, 1);
        checks += 2;
        if (we_seen !== 4'b1100) begin errors++; $display("FAIL sh_we: got %b, expected 1100", we_seen); end
        if (di_seen !== 32'hCAFECAFE) begin errors++; $display("FAIL sh_di: got %h, expected cafecafe", di_seen); end
        issue(1'b0, 2'b01, 1'b0, 14'h10A, 32'h0, 32'hFFFFCAFE, 1'b0, 1);
        issue(1'b0, 2'b00, 1'b0, 14'h10A, 32'h0, 32'hFFFFFFFE, 1'b0, 1);
        issue(1'b0, 2'b00, 1'b1, 14'h10B, 32'h0, 32'h000000CA, 1'b0, 1);
        drain();
    endtask

    task automatic test_errors();
        issue(1'b0, 2'b10, 1'b0, 14'h102, 32'h0, 32'h0, 1'b1, 1);
        checks++;
        if (we_seen !== 4'h0) begin errors++; $display("FAIL err_lw_we: got %b, expected 0000", we_seen); end
        issue(1'b1, 2'b01, 1'b0, 14'h101, 32'h0000FFFF, 32'h0, 1'b1, 1);
        checks++;
        if (we_seen !== 4'h0) begin errors++; $display("FAIL err_sh_we: got %b, expected 0000", we_seen); end
        issue(1'b1, 2'b11, 1'b0, 14'h100, 32'h00000000, 32'h0, 1'b1, 1);
        checks++;
        if (we_seen !== 4'h0) begin errors++; $display("FAIL err_size_we: got %b, expected 0000", we_seen); end
        @(negedge clk);
        checks++;
        if (bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL err_lat: rsp_valid=%b, expected 1", bus.rsp_valid); end
        @(posedge clk);
        #1;
        issue(1'b0, 2'b10, 1'b0, 14'h100, 32'h0, 32'hDEAD78EF, 1'b0, 1);
        drain();
    endtask

    task automatic test_back_to_back();
        bus.rsp_ready = 1'b0;
        issue(1'b0, 2'b10, 1'b0, 14'h100, 32'h0, 32'hDEAD78EF, 1'b0, 1);
        @(posedge clk);
        #1;
        sbq.push_back('{32'h0, 1'b0});
        bus.req_valid = 1'b1;
        bus.req_we = 1'b1;
        bus.req_size = 2'b10;
        bus.req_addr = 14'h104;
        bus.req_wdata = 32'hA5A5A5A5;
        repeat (5) begin
            @(negedge clk);
            checks += 4;
            if (bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL stall_valid: got %b, expected 1", bus.rsp_valid); end
            if (bus.rsp_rdata !== 32'hDEAD78EF) begin errors++; $display("FAIL stall_rdata: got %h, expected dead78ef", bus.rsp_rdata); end
            if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL stall_req_ready: got %b, expected 0", bus.req_ready); end
            if (bus.ram_we !== 4'h0) begin errors++; $display("FAIL stall_we: got %b, expected 0000", bus.ram_we); end
        end
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        checks += 3;
        if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL b2b_req_ready: got %b, expected 1", bus.req_ready); end
        if (bus.ram_we !== 4'b1111) begin errors++; $display("FAIL b2b_we: got %b, expected 1111", bus.ram_we); end
        if (bus.ram_di !== 32'hA5A5A5A5) begin errors++; $display("FAIL b2b_di: got %h, expected a5a5a5a5", bus.ram_di); end
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL b2b_sw_rsp: rsp_valid=%b, expected 1", bus.rsp_valid); end
        @(posedge clk);
        #1;
        drain();
        issue(1'b0, 2'b10, 1'b0, 14'h104, 32'h0, 32'hA5A5A5A5, 1'b0, 1);
        drain();
    endtask

    task automatic test_reset_mid();
        issue(1'b0, 2'b10, 1'b0, 14'h100, 32'h0, 32'h0, 1'b0, 0);
        rst = 1'b1;
        #1;
        checks += 2;
        if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid: got %b, expected 0", bus.rsp_valid); end
        if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_ready: got %b, expected 0", bus.req_ready); end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            checks += 2;
            if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL post_rst_ready: got %b, expected 1", bus.req_ready); end
            if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL post_rst_valid: got %b, expected 0", bus.rsp_valid); end
        end
        @(posedge clk);
        #1;
        issue(1'b0, 2'b00, 1'b1, 14'h100, 32'h0, 32'h000000EF, 1'b0, 1);
        drain();
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_we = 1'b0;
        bus.req_size = 2'b00;
        bus.req_unsigned = 1'b0;
        bus.req_addr = 14'h0;
        bus.req_wdata = 32'h0;
        bus.rsp_ready = 1'b1;
        test_reset();
        test_loads();
        test_store_byte();
        test_store_half();
        test_errors();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
